ascon_perm_controller: RTL and testbench

- FSM sequencer for the one-round-per-cycle ASCON permutation datapath, performing ASCON-128 encryption.
- Drives every datapath control strobe and the round index.
- Runs initialization (p^a, 12 rounds), associated-data blocks (p^b, 6 rounds), plaintext blocks (p^b) and finalization (p^a).
- Exchanges 64-bit data blocks with the host over a valid/ready handshake. Host supplies pre-padded blocks and the initial IV||K||N state on the datapath i_state.

---
 rtl/ascon_pkg.sv | 27 ++
 rtl/ascon_round_counter.sv | 44 ++++
 rtl/ascon_perm_controller.sv | 278 +++++++++++++++++++++++++++
 tb/tb_ascon_perm_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON permutation controller.
// Round indices follow the ASCON round-constant table (0..11).
package ascon_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INIT    = 3'd1,
      AD_WAIT = 3'd2,
      AD_PERM = 3'd3,
      PT_WAIT = 3'd4,
      PT_PERM = 3'd5,
      FIN     = 3'd6,
      DONE    = 3'd7
   } t_ctrl_state;

   localparam int unsigned C_ROUND_WIDTH = 4;

   localparam logic [C_ROUND_WIDTH-1:0] C_PA_FIRST_ROUND = 4'd0;
   localparam logic [C_ROUND_WIDTH-1:0] C_PB_FIRST_ROUND = 4'd6;
   localparam logic [C_ROUND_WIDTH-1:0] C_LAST_ROUND     = 4'd11;

   // Round that follows a given first round once the absorbed block has been mixed in.
   function automatic logic [C_ROUND_WIDTH-1:0] round_after(input logic [C_ROUND_WIDTH-1:0] first_round);
      return first_round + 4'd1;
   endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// Loadable 4-bit round index counter; saturates at the last round and flags it.
module ascon_round_counter
   import ascon_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     clear_i,
   input  logic                     load_i,
   input  logic [C_ROUND_WIDTH-1:0] load_value_i,
   input  logic                     incr_i,
   output logic [C_ROUND_WIDTH-1:0] round_o,
   output logic                     last_o
);

   logic [C_ROUND_WIDTH-1:0] round_q;
   logic [C_ROUND_WIDTH-1:0] round_d;

   // Next round index: clear beats load beats increment.
   always_comb begin
      round_d = round_q;
      if (clear_i) begin
         round_d = C_PA_FIRST_ROUND;
      end else if (load_i) begin
         round_d = load_value_i;
      end else if (incr_i && (round_q != C_LAST_ROUND)) begin
         round_d = round_q + 4'd1;
      end else begin
         round_d = round_q;
      end
   end

   // Round index register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         round_q <= C_PA_FIRST_ROUND;
      end else begin
         round_q <= round_d;
      end
   end

   assign round_o = round_q;
   assign last_o  = (round_q == C_LAST_ROUND);

endmodule

// File: rtl/ascon_perm_controller.sv
// Sequencer for the one-round-per-cycle ASCON-128 encryption datapath:
// initialization, AD absorption, plaintext encryption and finalization.
module ascon_perm_controller
   import ascon_pkg::*;
#(
   parameter int unsigned G_CNT_WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   i_start,
   input  logic                   i_abort,
   input  logic [G_CNT_WIDTH-1:0] i_num_ad,
   input  logic [G_CNT_WIDTH-1:0] i_num_pt,
   input  logic                   i_data_valid,
   output logic                   o_data_ready,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_cipher_valid,
   output logic                   o_tag_valid,
   output logic                   o_sys_enable,
   output logic                   o_mux_select,
   output logic                   o_enable_xor_key_begin,
   output logic                   o_enable_xor_data_begin,
   output logic                   o_enable_xor_key_end,
   output logic                   o_enable_xor_lsb_end,
   output logic                   o_enable_cipher_reg,
   output logic                   o_enable_tag_reg,
   output logic                   o_enable_state_reg,
   output logic [3:0]             o_round
);

   localparam logic [G_CNT_WIDTH-1:0] C_CNT_ZERO = {G_CNT_WIDTH{1'b0}};
   localparam logic [G_CNT_WIDTH-1:0] C_CNT_ONE  = {{(G_CNT_WIDTH-1){1'b0}}, 1'b1};

   t_ctrl_state              state_q;
   t_ctrl_state              state_d;
   logic [G_CNT_WIDTH-1:0]   ad_cnt_q;
   logic [G_CNT_WIDTH-1:0]   ad_cnt_d;
   logic [G_CNT_WIDTH-1:0]   pt_cnt_q;
   logic [G_CNT_WIDTH-1:0]   pt_cnt_d;
   logic                     cipher_valid_q;
   logic                     sys_en_q;

   logic                     rc_clear_s;
   logic                     rc_load_s;
   logic [C_ROUND_WIDTH-1:0] rc_load_val_s;
   logic                     rc_incr_s;
   logic [C_ROUND_WIDTH-1:0] rc_s;
   logic                     rc_last_s;
   logic                     ad_last_s;
   logic                     pt_last_s;

   logic                     data_ready_s;
   logic                     done_s;
   logic                     mux_select_s;
   logic                     xor_key_begin_s;
   logic                     xor_data_begin_s;
   logic                     xor_key_end_s;
   logic                     xor_lsb_end_s;
   logic                     cipher_reg_s;
   logic                     tag_reg_s;
   logic                     state_reg_s;
   logic [C_ROUND_WIDTH-1:0] round_s;

   ascon_round_counter u_round_counter (
      .clock        (clock),
      .reset_n      (reset_n),
      .clear_i      (rc_clear_s),
      .load_i       (rc_load_s),
      .load_value_i (rc_load_val_s),
      .incr_i       (rc_incr_s),
      .round_o      (rc_s),
      .last_o       (rc_last_s)
   );

   // The final block of each phase is the one seen while its down-counter reads one.
   assign ad_last_s = (ad_cnt_q == C_CNT_ONE);
   assign pt_last_s = (pt_cnt_q == C_CNT_ONE);

   // Next state, block counters and round-counter control; abort overrides everything.
   always_comb begin
      state_d       = state_q;
      ad_cnt_d      = ad_cnt_q;
      pt_cnt_d      = pt_cnt_q;
      rc_clear_s    = 1'b0;
      rc_load_s     = 1'b0;
      rc_load_val_s = C_PA_FIRST_ROUND;
      rc_incr_s     = 1'b0;
      if (i_abort) begin
         state_d    = IDLE;
         ad_cnt_d   = C_CNT_ZERO;
         pt_cnt_d   = C_CNT_ZERO;
         rc_clear_s = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  ad_cnt_d      = i_num_ad;
                  pt_cnt_d      = (i_num_pt == C_CNT_ZERO) ? C_CNT_ONE : i_num_pt;
                  rc_load_s     = 1'b1;
                  rc_load_val_s = C_PA_FIRST_ROUND;
                  state_d       = INIT;
               end else begin
                  state_d = IDLE;
               end
            end
            INIT: begin
               if (rc_last_s) begin
                  state_d = (ad_cnt_q != C_CNT_ZERO) ? AD_WAIT : PT_WAIT;
               end else begin
                  rc_incr_s = 1'b1;
               end
            end
            AD_WAIT: begin
               if (i_data_valid) begin
                  rc_load_s     = 1'b1;
                  rc_load_val_s = round_after(C_PB_FIRST_ROUND);
                  state_d       = AD_PERM;
               end else begin
                  state_d = AD_WAIT;
               end
            end
            AD_PERM: begin
               if (rc_last_s) begin
                  ad_cnt_d = (ad_cnt_q != C_CNT_ZERO) ? (ad_cnt_q - C_CNT_ONE) : ad_cnt_q;
                  state_d  = ad_last_s ? PT_WAIT : AD_WAIT;
               end else begin
                  rc_incr_s = 1'b1;
               end
            end
            PT_WAIT: begin
               if (i_data_valid) begin
                  rc_load_s = 1'b1;
                  if (pt_last_s) begin
                     rc_load_val_s = round_after(C_PA_FIRST_ROUND);
                     state_d       = FIN;
                  end else begin
                     rc_load_val_s = round_after(C_PB_FIRST_ROUND);
                     state_d       = PT_PERM;
                  end
               end else begin
                  state_d = PT_WAIT;
               end
            end
            PT_PERM: begin
               if (rc_last_s) begin
                  pt_cnt_d = (pt_cnt_q != C_CNT_ZERO) ? (pt_cnt_q - C_CNT_ONE) : pt_cnt_q;
                  state_d  = PT_WAIT;
               end else begin
                  rc_incr_s = 1'b1;
               end
            end
            FIN: begin
               if (rc_last_s) begin
                  state_d = DONE;
               end else begin
                  rc_incr_s = 1'b1;
               end
            end
            DONE: begin
               rc_clear_s = 1'b1;
               state_d    = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Datapath strobes; the abort cycle only clears the datapath, so every strobe stays low.
   always_comb begin
      data_ready_s     = 1'b0;
      done_s           = 1'b0;
      mux_select_s     = 1'b0;
      xor_key_begin_s  = 1'b0;
      xor_data_begin_s = 1'b0;
      xor_key_end_s    = 1'b0;
      xor_lsb_end_s    = 1'b0;
      cipher_reg_s     = 1'b0;
      tag_reg_s        = 1'b0;
      state_reg_s      = 1'b0;
      round_s          = C_PA_FIRST_ROUND;
      if (!i_abort) begin
         case (state_q)
            INIT: begin
               round_s       = rc_s;
               state_reg_s   = 1'b1;
               mux_select_s  = (rc_s != C_PA_FIRST_ROUND);
               xor_key_end_s = rc_last_s;
               xor_lsb_end_s = rc_last_s && (ad_cnt_q == C_CNT_ZERO);
            end
            AD_WAIT: begin
               data_ready_s     = 1'b1;
               round_s          = C_PB_FIRST_ROUND;
               mux_select_s     = 1'b1;
               xor_data_begin_s = 1'b1;
               state_reg_s      = i_data_valid;
            end
            AD_PERM: begin
               round_s       = rc_s;
               mux_select_s  = 1'b1;
               state_reg_s   = 1'b1;
               xor_lsb_end_s = rc_last_s && ad_last_s;
            end
            PT_WAIT: begin
               data_ready_s     = 1'b1;
               mux_select_s     = 1'b1;
               xor_data_begin_s = 1'b1;
               state_reg_s      = i_data_valid;
               cipher_reg_s     = i_data_valid;
               // The last block goes straight into finalization with the key folded in first.
               if (pt_last_s) begin
                  round_s         = C_PA_FIRST_ROUND;
                  xor_key_begin_s = 1'b1;
               end else begin
                  round_s         = C_PB_FIRST_ROUND;
                  xor_key_begin_s = 1'b0;
               end
            end
            PT_PERM: begin
               round_s      = rc_s;
               mux_select_s = 1'b1;
               state_reg_s  = 1'b1;
            end
            FIN: begin
               round_s       = rc_s;
               mux_select_s  = 1'b1;
               state_reg_s   = 1'b1;
               xor_key_end_s = rc_last_s;
               tag_reg_s     = rc_last_s;
            end
            DONE: begin
               done_s = 1'b1;
            end
            default: begin
               done_s = 1'b0;
            end
         endcase
      end else begin
         round_s = C_PA_FIRST_ROUND;
      end
   end

   // FSM state, block counters and the registered status flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         ad_cnt_q       <= C_CNT_ZERO;
         pt_cnt_q       <= C_CNT_ZERO;
         cipher_valid_q <= 1'b0;
         sys_en_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         ad_cnt_q       <= ad_cnt_d;
         pt_cnt_q       <= pt_cnt_d;
         cipher_valid_q <= cipher_reg_s;
         sys_en_q       <= 1'b1;
      end
   end

   assign o_data_ready            = data_ready_s;
   assign o_busy                  = (state_q != IDLE);
   assign o_done                  = done_s;
   assign o_tag_valid             = done_s;
   assign o_cipher_valid          = cipher_valid_q;
   assign o_sys_enable            = sys_en_q && !i_abort;
   assign o_mux_select            = mux_select_s;
   assign o_enable_xor_key_begin  = xor_key_begin_s;
   assign o_enable_xor_data_begin = xor_data_begin_s;
   assign o_enable_xor_key_end    = xor_key_end_s;
   assign o_enable_xor_lsb_end    = xor_lsb_end_s;
   assign o_enable_cipher_reg     = cipher_reg_s;
   assign o_enable_tag_reg        = tag_reg_s;
   assign o_enable_state_reg      = state_reg_s;
   assign o_round                 = round_s;

endmodule

// File: tb/tb_ascon_perm_controller.sv
// Self-checking bench for ascon_perm_controller: directed table, stall/abort/reset
// sequences and randomized transactions against a cycle-count/round-sum model.
module tb_ascon_perm_controller;

   logic       clock;
   logic       reset_n;
   logic       i_start;
   logic       i_abort;
   logic [7:0] i_num_ad;
   logic [7:0] i_num_pt;
   logic       i_data_valid;
   logic       o_data_ready, o_busy, o_done, o_cipher_valid, o_tag_valid, o_sys_enable;
   logic       o_mux_select, o_enable_xor_key_begin, o_enable_xor_data_begin;
   logic       o_enable_xor_key_end, o_enable_xor_lsb_end, o_enable_cipher_reg;
   logic       o_enable_tag_reg, o_enable_state_reg;
   logic [3:0] o_round;
   logic [17:0] all_o;

   int comp_cnt = 0;
   int fail_cnt = 0;

   // Results of the most recent transaction.
   int res_done, res_hs, res_cv, res_sum, res_rounds, res_stalls;
   int res_lsb_cnt, res_key_end_cnt, res_tag_cnt, res_lsb_cyc, res_tag_cyc;
   int hs_cyc[64];

   typedef struct {
      int ad;
      int pt;
      int exp_done;
      int exp_hs;
      int exp_cv;
      int exp_sum;
   } vec_t;
   vec_t tbl[6];

   ascon_perm_controller #(.G_CNT_WIDTH(8)) dut (
      .clock                   (clock),
      .reset_n                 (reset_n),
      .i_start                 (i_start),
      .i_abort                 (i_abort),
      .i_num_ad                (i_num_ad),
      .i_num_pt                (i_num_pt),
      .i_data_valid            (i_data_valid),
      .o_data_ready            (o_data_ready),
      .o_busy                  (o_busy),
      .o_done                  (o_done),
      .o_cipher_valid          (o_cipher_valid),
      .o_tag_valid             (o_tag_valid),
      .o_sys_enable            (o_sys_enable),
      .o_mux_select            (o_mux_select),
      .o_enable_xor_key_begin  (o_enable_xor_key_begin),
      .o_enable_xor_data_begin (o_enable_xor_data_begin),
      .o_enable_xor_key_end    (o_enable_xor_key_end),
      .o_enable_xor_lsb_end    (o_enable_xor_lsb_end),
      .o_enable_cipher_reg     (o_enable_cipher_reg),
      .o_enable_tag_reg        (o_enable_tag_reg),
      .o_enable_state_reg      (o_enable_state_reg),
      .o_round                 (o_round)
   );

   assign all_o = {o_data_ready, o_busy, o_done, o_cipher_valid, o_tag_valid, o_sys_enable,
                   o_mux_select, o_enable_xor_key_begin, o_enable_xor_data_begin,
                   o_enable_xor_key_end, o_enable_xor_lsb_end, o_enable_cipher_reg,
                   o_enable_tag_reg, o_enable_state_reg, o_round};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      comp_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One complete transaction starting from IDLE; per-cycle rules are checked inline,
   // totals are left in res_* for the caller to compare against its expectation.
   task automatic run_txn(input int ad, input int pt, input int stall_pct,
                          input int last_stall, input bit hold_start);
      int  cyc, nblk, stall_left, prev_round;
      bit  prev_cr, prev_stall, done_seen, rdy, v, last;
      nblk = ad + ((pt == 0) ? 1 : pt);
      res_hs = 0; res_cv = 0; res_sum = 0; res_rounds = 0; res_stalls = 0;
      res_lsb_cnt = 0; res_key_end_cnt = 0; res_tag_cnt = 0; res_lsb_cyc = -1;
      res_tag_cyc = -1; res_done = -1;
      @(posedge clock); #1;
      i_start = 1'b1; i_num_ad = 8'(ad); i_num_pt = 8'(pt); i_data_valid = 1'b0;
      #1;
      chk("start_cycle_busy", o_busy, 0);
      cyc = 0; prev_cr = 1'b0; prev_stall = 1'b0; prev_round = 0;
      stall_left = last_stall; done_seen = 1'b0;
      while (!done_seen && cyc < 3000) begin
         @(posedge clock); #1;
         cyc++;
         i_start  = hold_start;
         i_num_ad = 8'($urandom_range(0, 255));
         i_num_pt = 8'($urandom_range(0, 255));
         rdy = o_data_ready;
         v = ($urandom_range(0, 99) >= stall_pct);
         if (rdy && (res_hs == nblk - 1) && (stall_left > 0)) begin
            v = 1'b0;
            stall_left--;
         end
         i_data_valid = v;
         #1;
         chk("busy", o_busy, 1);
         chk("sys_enable", o_sys_enable, 1);
         chk("cipher_valid_follows", o_cipher_valid, prev_cr);
         prev_cr = o_enable_cipher_reg;
         if (cyc <= 12) begin
            chk("init_round", o_round, cyc - 1);
            chk("init_state_reg", o_enable_state_reg, 1);
         end
         if (cyc == 1) chk("init_mux_load", o_mux_select, 0);
         if (rdy && !v) begin
            res_stalls++;
            chk("stall_state_reg", o_enable_state_reg, 0);
            chk("stall_cipher_reg", o_enable_cipher_reg, 0);
            if (prev_stall) chk("stall_round_held", o_round, prev_round);
         end
         if (rdy && v) begin
            res_hs++;
            hs_cyc[res_hs] = cyc;
            last = (res_hs == nblk);
            chk("hs_round", o_round, last ? 0 : 6);
            chk("hs_key_begin", o_enable_xor_key_begin, last);
            chk("hs_data_begin", o_enable_xor_data_begin, 1);
            chk("hs_state_reg", o_enable_state_reg, 1);
            chk("hs_mux", o_mux_select, 1);
            chk("hs_cipher_reg", o_enable_cipher_reg, (res_hs > ad) ? 1 : 0);
         end
         prev_stall = rdy && !v;
         prev_round = o_round;
         if (o_enable_state_reg) begin
            res_sum += o_round;
            res_rounds++;
         end
         if (o_cipher_valid) res_cv++;
         if (o_enable_xor_lsb_end) begin res_lsb_cnt++; res_lsb_cyc = cyc; end
         if (o_enable_xor_key_end) res_key_end_cnt++;
         if (o_enable_tag_reg) begin res_tag_cnt++; res_tag_cyc = cyc; end
         if (o_done) begin
            done_seen = 1'b1;
            res_done = cyc;
            chk("tag_valid_eq_done", o_tag_valid, 1);
         end
      end
      chk("done_within_budget", done_seen, 1);
      chk("lsb_end_once", res_lsb_cnt, 1);
      chk("key_end_twice", res_key_end_cnt, 2);
      chk("tag_reg_once", res_tag_cnt, 1);
      chk("tag_before_done", res_tag_cyc, res_done - 1);
      chk("lsb_end_cycle", res_lsb_cyc, (ad == 0) ? 12 : hs_cyc[ad] + 5);
      chk("rounds_executed", res_rounds, 24 + 6 * (nblk - 1));
      @(posedge clock); #1;
      i_start = 1'b0; i_data_valid = 1'b0;
      #1;
      chk("back_to_idle", o_busy, 0);
      chk("done_one_cycle", o_done, 0);
   endtask

   initial begin
      tbl[0] = '{ad: 0, pt: 1, exp_done: 25, exp_hs: 1, exp_cv: 1, exp_sum: 132};
      tbl[1] = '{ad: 2, pt: 3, exp_done: 49, exp_hs: 5, exp_cv: 3, exp_sum: 336};
      tbl[2] = '{ad: 0, pt: 0, exp_done: 25, exp_hs: 1, exp_cv: 1, exp_sum: 132};
      tbl[3] = '{ad: 1, pt: 1, exp_done: 31, exp_hs: 2, exp_cv: 1, exp_sum: 183};
      tbl[4] = '{ad: 3, pt: 0, exp_done: 43, exp_hs: 4, exp_cv: 1, exp_sum: 285};
      tbl[5] = '{ad: 0, pt: 4, exp_done: 43, exp_hs: 4, exp_cv: 4, exp_sum: 285};

      reset_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
      i_num_ad = 8'd0; i_num_pt = 8'd0; i_data_valid = 1'b0;
      #3;
      chk("reset_outputs_zero", all_o, 0);
      @(posedge clock); @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #2;
      chk("idle_sys_enable", o_sys_enable, 1);
      chk("idle_busy", o_busy, 0);

      // Directed table, valid always high.
      for (int k = 0; k < 6; k++) begin
         run_txn(tbl[k].ad, tbl[k].pt, 0, 0, 1'b0);
         chk("tbl_done_cycle", res_done, tbl[k].exp_done);
         chk("tbl_handshakes", res_hs, tbl[k].exp_hs);
         chk("tbl_cipher_valid", res_cv, tbl[k].exp_cv);
         chk("tbl_round_sum", res_sum, tbl[k].exp_sum);
      end

      // Five-cycle stall on the final block; i_start held high while busy.
      run_txn(0, 1, 0, 5, 1'b1);
      chk("stall_done_cycle", res_done, 30);
      chk("stall_round_sum", res_sum, 132);
      chk("stall_count", res_stalls, 5);

      // Abort in FIN at round 5 (cycle 18 for ad=0, pt=1).
      @(posedge clock); #1;
      i_start = 1'b1; i_num_ad = 8'd0; i_num_pt = 8'd1; i_data_valid = 1'b1;
      for (int c = 1; c <= 18; c++) begin
         @(posedge clock); #1;
         i_start = 1'b0;
      end
      #1;
      chk("abort_pre_round", o_round, 5);
      chk("abort_pre_state_reg", o_enable_state_reg, 1);
      i_abort = 1'b1;
      #1;
      chk("abort_sys_enable", o_sys_enable, 0);
      chk("abort_state_reg", o_enable_state_reg, 0);
      chk("abort_round", o_round, 0);
      @(posedge clock); #1;
      i_abort = 1'b0;
      #1;
      chk("abort_idle", o_busy, 0);
      chk("abort_sys_enable_back", o_sys_enable, 1);
      begin
         int dn = 0;
         for (int c = 0; c < 30; c++) begin
            @(posedge clock); #2;
            dn += int'(o_done);
         end
         chk("abort_no_done", dn, 0);
      end
      run_txn(1, 2, 0, 0, 1'b0);
      chk("after_abort_done", res_done, 37);

      // Abort beats start in IDLE.
      @(posedge clock); #1;
      i_start = 1'b1; i_abort = 1'b1;
      #1;
      chk("abort_start_sys_en", o_sys_enable, 0);
      @(posedge clock); #1;
      i_start = 1'b0; i_abort = 1'b0;
      #1;
      chk("abort_start_idle", o_busy, 0);

      // Asynchronous reset in AD_PERM (cycle 15, round 8).
      @(posedge clock); #1;
      i_start = 1'b1; i_num_ad = 8'd2; i_num_pt = 8'd1; i_data_valid = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         @(posedge clock); #1;
         i_start = 1'b0;
      end
      #1;
      chk("pre_reset_round", o_round, 8);
      reset_n = 1'b0;
      #1;
      chk("async_reset_outputs", all_o, 0);
      @(posedge clock); @(posedge clock); #1;
      reset_n = 1'b1; i_data_valid = 1'b0;
      @(posedge clock); #2;
      chk("post_reset_idle", o_busy, 0);
      chk("post_reset_cv", o_cipher_valid, 0);
      chk("post_reset_sys_en", o_sys_enable, 1);

      // Randomized transactions against the block-count model.
      for (int t = 0; t < 10; t++) begin
         int ad, pt, pte, nblk;
         ad = $urandom_range(0, 4);
         pt = $urandom_range(0, 4);
         pte = (pt == 0) ? 1 : pt;
         nblk = ad + pte;
         run_txn(ad, pt, 35, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         chk("rnd_done_cycle", res_done, 25 + 6 * (nblk - 1) + res_stalls);
         chk("rnd_handshakes", res_hs, nblk);
         chk("rnd_cipher_valid", res_cv, pte);
         chk("rnd_round_sum", res_sum, 132 + 51 * (nblk - 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, fail_cnt);
      $finish;
   end

endmodule
